// File: rtl/qreg_mult_ctrl_if.sv
// Handshake and strobe bundle between the multiplier control FSM and its
// sequencer / Q-register datapath.
interface qreg_mult_ctrl_if;
   logic start;
   logic q0;
   logic ldp;
   logic clr_acc;
   logic l_and;
   logic cta;
   logic busy;
   logic done;

   modport master (
      input  start,
      input  q0,
      output ldp,
      output clr_acc,
      output l_and,
      output cta,
      output busy,
      output done
   );

   modport slave (
      output start,
      output q0,
      input  ldp,
      input  clr_acc,
      input  l_and,
      input  cta,
      input  busy,
      input  done
   );
endinterface

// File: rtl/qreg_mult_ctrl.sv
// Moore control FSM for the shift-add multiplier: loads Q, then per bit
// tests q0, optionally accumulates, and shifts, counting N bit-steps.
module qreg_mult_ctrl #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   qreg_mult_ctrl_if.master bus
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      TEST  = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [5:0]    outs;

   // Output bits: {ldp, clr_acc, l_and, cta, busy, done} for a given state.
   function automatic logic [5:0] decode(input state_t s);
      logic [5:0] o;
      case (s)
         IDLE:    o = 6'b000000;
         LOAD:    o = 6'b110010;
         TEST:    o = 6'b000010;
         ADD:     o = 6'b001010;
         SHIFT:   o = 6'b000110;
         DONE:    o = 6'b000011;
         default: o = 6'b000000;
      endcase
      return o;
   endfunction

   // Next-state and step-counter logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = LOAD;
            else           state_nxt = IDLE;
         end
         LOAD: begin
            cnt_nxt   = {CW{1'b0}};
            state_nxt = TEST;
         end
         TEST: begin
            if (bus.q0) state_nxt = ADD;
            else        state_nxt = SHIFT;
         end
         ADD: state_nxt = SHIFT;
         SHIFT: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == LAST) state_nxt = DONE;
            else             state_nxt = TEST;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= {CW{1'b0}};
         outs  <= 6'b000000;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         outs  <= decode(state_nxt);
      end
   end

   assign bus.ldp     = outs[5];
   assign bus.clr_acc = outs[4];
   assign bus.l_and   = outs[3];
   assign bus.cta     = outs[2];
   assign bus.busy    = outs[1];
   assign bus.done    = outs[0];

endmodule

// File: tb/tb_qreg_mult_ctrl.sv
// Self-checking bench: a Q-register model feeds q0, and per-operation pulse
// counts and done latency are compared with values derived from the multiplier.
module tb_qreg_mult_ctrl;
   localparam int N    = 4;
   localparam int HOLD = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   qreg_mult_ctrl_if bus();
   qreg_mult_ctrl #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [N-1:0] mult = '0;
   logic [N-1:0] qm   = '0;
   int n_ldp = 0, n_clr = 0, n_land = 0, n_cta = 0, n_busy = 0, n_bad = 0;
   int done_q[$];
   int e0, s_ldp, s_clr, s_land, s_cta, s_busy, s_bad, s_done;

   wire [5:0] obs = {bus.ldp, bus.clr_acc, bus.l_and, bus.cta, bus.busy, bus.done};

   assign bus.q0 = qm[0];

   always @(posedge clk) cyc <= cyc + 1;

   // Q register model: parallel load on ldp, shift right on cta.
   always @(posedge clk) begin
      if (bus.ldp)      qm <= mult;
      else if (bus.cta) qm <= qm >> 1;
   end

   // Mid-cycle monitor: cumulative pulse counts and done timestamps.
   always @(negedge clk) begin
      if (bus.ldp)     n_ldp  <= n_ldp + 1;
      if (bus.clr_acc) n_clr  <= n_clr + 1;
      if (bus.l_and)   n_land <= n_land + 1;
      if (bus.cta)     n_cta  <= n_cta + 1;
      if (bus.busy)    n_busy <= n_busy + 1;
      if ((bus.ldp && bus.cta) || (bus.l_and && bus.cta) ||
          (!bus.busy && (bus.ldp || bus.clr_acc || bus.l_and || bus.cta || bus.done)))
         n_bad <= n_bad + 1;
      if (bus.done) done_q.push_back(cyc);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int popc(input int m);
      int c = 0;
      for (int i = 0; i < N; i++) c += (m >> i) & 1;
      return c;
   endfunction

   task automatic snap();
      e0     = cyc;
      s_ldp  = n_ldp;
      s_clr  = n_clr;
      s_land = n_land;
      s_cta  = n_cta;
      s_busy = n_busy;
      s_bad  = n_bad;
      s_done = done_q.size();
   endtask

   task automatic start_op(input int m);
      mult = m[N-1:0];
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      snap();
   endtask

   task automatic finish_op(input int m, input bit mid);
      bit got = 1'b0;
      int lat = 1 + 2 * N + popc(m);
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         #1;
         if (k == 0) check_val("load_strobes", {30'd0, bus.ldp, bus.clr_acc}, 32'd3);
         bus.start = (mid && cyc == e0 + 4) ? 1'b1 : 1'b0;
         if (done_q.size() > s_done) got = 1'b1;
      end
      check_val("done_seen", {31'd0, got}, 32'd1);
      if (got) check_val("done_latency", done_q[s_done] - e0, lat);
      check_val("ldp_count", n_ldp - s_ldp, 1);
      check_val("clr_count", n_clr - s_clr, 1);
      check_val("land_count", n_land - s_land, popc(m));
      check_val("cta_count", n_cta - s_cta, N);
      check_val("busy_cycles", n_busy - s_busy, lat + 1);
      check_val("overlap", n_bad - s_bad, 0);
      check_val("q_final", {{(32-N){1'b0}}, qm}, 32'd0);
      @(negedge clk);
      #1;
      check_val("idle_after", {30'd0, bus.busy, bus.done}, 32'd0);
   endtask

   initial begin
      int nd, per;
      bus.start = 1'b1;
      mult      = 4'd7;
      #1 rst = 1'b1;
      // Reset held with start high: everything quiet.
      repeat (2) begin
         @(negedge clk);
         #1;
         check_val("reset_outs", {26'd0, obs}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      snap();
      finish_op(7, 1'b0);

      start_op(7);  finish_op(7, 1'b0);
      start_op(0);  finish_op(0, 1'b0);
      start_op(15); finish_op(15, 1'b0);
      start_op(7);  finish_op(7, 1'b1);

      // Reset in the middle of the third shift.
      start_op(7);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         bus.start = 1'b0;
         if (n_cta - s_cta == 3) break;
      end
      check_val("third_shift_seen", n_cta - s_cta, 3);
      rst = 1'b1;
      #1;
      check_val("rst_outs", {26'd0, obs}, 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_val("idle_after_rst", {31'd0, bus.busy}, 32'd0);
      start_op(7);  finish_op(7, 1'b0);

      // Start held high: back-to-back operations, LOAD..DONE plus one IDLE cycle apart.
      mult = 4'd5;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      snap();
      repeat (HOLD) @(posedge clk);
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (!bus.busy) break;
      end
      per = 1 + 2 * N + popc(5) + 2;
      nd  = done_q.size() - s_done;
      check_val("held_ops", nd, HOLD / per + 1);
      if (nd > 0) check_val("held_first", done_q[s_done] - e0, 1 + 2 * N + popc(5));
      for (int i = 1; i < nd; i++)
         check_val("held_period", done_q[s_done + i] - done_q[s_done + i - 1], per);
      check_val("held_land", n_land - s_land, nd * popc(5));
      check_val("held_cta", n_cta - s_cta, nd * N);
      check_val("held_overlap", n_bad - s_bad, 0);

      for (int i = 0; i < 8; i++) begin
         int m   = $urandom_range(0, 15);
         bit mid = 1'($urandom_range(0, 1));
         start_op(m);
         finish_op(m, mid);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
